// File: rtl/sh4_fpu_issue.sv
// Issue controller and write-port scoreboard in front of sh4_fpu: tracks pending
// FP register writes, resolves RAW/WAW/port hazards and dispatches FMA/DIV/CMP ops.
module sh4_fpu_issue #(
  parameter int FMA_LAT = 4,
  parameter int DIV_LAT = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_fop,
  input  logic        req_bank,
  input  logic [3:0]  req_rn,
  input  logic [3:0]  req_rm,
  output logic        iss_fma,
  output logic        iss_div,
  output logic        iss_cmp,
  output logic        iss_bad,
  output logic [4:0]  iss_tag,
  output logic        wb_exp_valid,
  output logic [4:0]  wb_exp_tag,
  output logic [31:0] busy
);

  localparam int CW = $clog2(DIV_LAT + 1);

  localparam logic [3:0] FOP_FADD    = 4'h0;
  localparam logic [3:0] FOP_FSUB    = 4'h1;
  localparam logic [3:0] FOP_FMUL    = 4'h2;
  localparam logic [3:0] FOP_FDIV    = 4'h3;
  localparam logic [3:0] FOP_FCMP_EQ = 4'h4;
  localparam logic [3:0] FOP_FCMP_GT = 4'h5;
  localparam logic [3:0] FOP_FMAC    = 4'h6;
  localparam logic [3:0] FOP_FSQRT   = 4'h7;

  typedef enum logic [1:0] {CLS_FMA, CLS_DIV, CLS_CMP, CLS_BAD} fop_cls_e;

  fop_cls_e cls;
  logic     rd_rm;
  logic     rd_r0;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    cls   = CLS_BAD;
    rd_rm = 1'b1;
    rd_r0 = 1'b0;
    case (req_fop)
      FOP_FADD, FOP_FSUB, FOP_FMUL: cls = CLS_FMA;
      FOP_FMAC: begin
        cls   = CLS_FMA;
        rd_r0 = 1'b1;
      end
      FOP_FDIV:  cls = CLS_DIV;
      FOP_FSQRT: begin
        cls   = CLS_DIV;
        rd_rm = 1'b0;
      end
      FOP_FCMP_EQ, FOP_FCMP_GT: cls = CLS_CMP;
      default: cls = CLS_BAD;
    endcase
  end

  logic [4:0] dst_tag;
  logic [4:0] rm_tag;
  logic [4:0] r0_tag;

  assign dst_tag = {req_bank, req_rn};
  assign rm_tag  = {req_bank, req_rm};
  assign r0_tag  = {req_bank, 4'h0};

  // rsv[i] is the write-port slot i cycles from the current one.
  logic [DIV_LAT:0] rsv_vld;
  logic [4:0]       rsv_tag [DIV_LAT+1];
  logic [CW-1:0]    div_cnt;

  logic src_clear;
  logic slot_free;

  always_comb begin
    src_clear = !busy[dst_tag] && !(rd_rm && busy[rm_tag]) && !(rd_r0 && busy[r0_tag]);
    case (cls)
      CLS_FMA: slot_free = !rsv_vld[FMA_LAT];
      CLS_DIV: slot_free = (div_cnt == '0) && !rsv_vld[DIV_LAT];
      default: slot_free = 1'b1;
    endcase
    req_ready = rst && req_valid && ((cls == CLS_BAD) || (src_clear && slot_free));
  end

  assign iss_fma      = req_ready && (cls == CLS_FMA);
  assign iss_div      = req_ready && (cls == CLS_DIV);
  assign iss_cmp      = req_ready && (cls == CLS_CMP);
  assign iss_bad      = req_ready && (cls == CLS_BAD);
  assign iss_tag      = req_ready ? dst_tag : 5'd0;
  assign wb_exp_valid = rsv_vld[0];
  assign wb_exp_tag   = rsv_tag[0];

  logic [DIV_LAT:0] rsv_vld_nxt;
  logic [4:0]       rsv_tag_nxt [DIV_LAT+1];
  logic [31:0]      busy_nxt;
  logic [CW-1:0]    div_cnt_nxt;

  always_comb begin
    rsv_vld_nxt = {1'b0, rsv_vld[DIV_LAT:1]};
    for (int i = 0; i < DIV_LAT; i++) rsv_tag_nxt[i] = rsv_tag[i+1];
    rsv_tag_nxt[DIV_LAT] = 5'd0;
    // Slot L seen this cycle becomes slot L-1 after the shift.
    if (iss_fma) begin
      rsv_vld_nxt[FMA_LAT-1] = 1'b1;
      rsv_tag_nxt[FMA_LAT-1] = dst_tag;
    end
    if (iss_div) begin
      rsv_vld_nxt[DIV_LAT-1] = 1'b1;
      rsv_tag_nxt[DIV_LAT-1] = dst_tag;
    end

    busy_nxt = busy;
    if (rsv_vld[0]) busy_nxt[rsv_tag[0]] = 1'b0;
    if (iss_fma || iss_div) busy_nxt[dst_tag] = 1'b1;

    div_cnt_nxt = div_cnt;
    if (iss_div) div_cnt_nxt = CW'(DIV_LAT - 1);
    else if (div_cnt != '0) div_cnt_nxt = div_cnt - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: the tag array is reset too: entry 0 is a visible output with a defined reset value.
      rsv_vld <= '0;
      for (int i = 0; i <= DIV_LAT; i++) rsv_tag[i] <= 5'd0;
      busy    <= '0;
      div_cnt <= '0;
    end else begin
      // NOTE: non-blocking updates so every register samples the pre-edge values.
      rsv_vld <= rsv_vld_nxt;
      for (int i = 0; i <= DIV_LAT; i++) rsv_tag[i] <= rsv_tag_nxt[i];
      busy    <= busy_nxt;
      div_cnt <= div_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_sh4_fpu_issue.sv
// Bench for sh4_fpu_issue: directed scenarios with literal expectations, then random
// traffic compared every cycle against a pending-write-list model.
module tb_sh4_fpu_issue;

  localparam int FMA_LAT = 4;
  localparam int DIV_LAT = 12;

  localparam logic [3:0] FADD = 4'h0, FSUB = 4'h1, FMUL = 4'h2, FDIV = 4'h3;
  localparam logic [3:0] FCEQ = 4'h4, FCGT = 4'h5, FMAC = 4'h6, FSQRT = 4'h7;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_fop;
  logic        req_bank;
  logic [3:0]  req_rn;
  logic [3:0]  req_rm;
  logic        iss_fma, iss_div, iss_cmp, iss_bad;
  logic [4:0]  iss_tag;
  logic        wb_exp_valid;
  logic [4:0]  wb_exp_tag;
  logic [31:0] busy;

  sh4_fpu_issue #(.FMA_LAT(FMA_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_fop(req_fop),
    .req_bank(req_bank), .req_rn(req_rn), .req_rm(req_rm),
    .iss_fma(iss_fma), .iss_div(iss_div), .iss_cmp(iss_cmp), .iss_bad(iss_bad),
    .iss_tag(iss_tag), .wb_exp_valid(wb_exp_valid), .wb_exp_tag(wb_exp_tag),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: list of scheduled register writes with their absolute writeback cycle.
  typedef struct {
    int         wb;
    logic [4:0] tag;
  } pend_t;

  pend_t pend[$];
  int    now      = 0;
  int    div_free = 0;
  int    t0       = 0;
  logic  obs_ready;

  int          wb_log   [64];
  logic [31:0] busy_log [64];
  logic [4:0]  tag_log  [64];

  // 0 = FMA, 1 = DIV, 2 = CMP, 3 = BAD
  function automatic int cls_of(input logic [3:0] f);
    if (f == FADD || f == FSUB || f == FMUL || f == FMAC) return 0;
    if (f == FDIV || f == FSQRT) return 1;
    if (f == FCEQ || f == FCGT) return 2;
    return 3;
  endfunction

  function automatic bit m_busy(input logic [4:0] t);
    foreach (pend[i]) if (pend[i].tag == t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit slot_taken(input int c);
    foreach (pend[i]) if (pend[i].wb == c) return 1'b1;
    return 1'b0;
  endfunction

  task automatic run_cycle();
    int          c;
    int          rel;
    bit          ok;
    bit          e_ready;
    logic [4:0]  dt, rt, zt;
    logic [31:0] e_busy;
    bit          e_wbv;
    logic [4:0]  e_wbt;
    logic [3:0]  e_iss;
    @(negedge clk);
    c  = cls_of(req_fop);
    dt = {req_bank, req_rn};
    rt = {req_bank, req_rm};
    zt = {req_bank, 4'h0};
    ok = 1'b1;
    if (c != 3) begin
      if (m_busy(dt)) ok = 1'b0;
      if (req_fop != FSQRT && m_busy(rt)) ok = 1'b0;
      if (req_fop == FMAC && m_busy(zt)) ok = 1'b0;
      if (c == 0 && slot_taken(now + FMA_LAT)) ok = 1'b0;
      if (c == 1 && (now < div_free || slot_taken(now + DIV_LAT))) ok = 1'b0;
    end
    e_ready = rst && req_valid && ok;
    e_busy = '0;
    e_wbv  = 1'b0;
    e_wbt  = '0;
    foreach (pend[i]) begin
      e_busy[pend[i].tag] = 1'b1;
      if (pend[i].wb == now) begin
        e_wbv = 1'b1;
        e_wbt = pend[i].tag;
      end
    end
    e_iss = e_ready ? (4'b1000 >> c) : 4'b0000;

    check("req_ready", req_ready, e_ready);
    check("iss_onehot", {iss_fma, iss_div, iss_cmp, iss_bad}, e_iss);
    if (e_ready) check("iss_tag", iss_tag, dt);
    check("wb_exp_valid", wb_exp_valid, e_wbv);
    if (e_wbv) check("wb_exp_tag", wb_exp_tag, e_wbt);
    check("busy", busy, e_busy);

    obs_ready = req_ready;
    rel = now - t0;
    if (rel >= 0 && rel < 64) begin
      wb_log[rel]   = (wb_exp_valid === 1'b1) ? int'(wb_exp_tag) : -1;
      busy_log[rel] = busy;
      tag_log[rel]  = iss_tag;
    end

    if (!rst) begin
      pend.delete();
      div_free = 0;
    end else if (e_ready && c == 0) begin
      pend.push_back('{wb: now + FMA_LAT, tag: dt});
    end else if (e_ready && c == 1) begin
      pend.push_back('{wb: now + DIV_LAT, tag: dt});
      div_free = now + DIV_LAT;
    end
    now++;
    for (int i = pend.size() - 1; i >= 0; i--) if (pend[i].wb < now) pend.delete(i);

    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) run_cycle();
  endtask

  task automatic scen_reset();
    rst       = 1'b0;
    req_valid = 1'b0;
    run_cycle();
    rst = 1'b1;
    t0  = now;
    for (int i = 0; i < 64; i++) wb_log[i] = -1;
  endtask

  // Offers one op and holds it until accepted; acc is the acceptance cycle, -1 on timeout.
  task automatic offer(input logic [3:0] f, input logic b, input logic [3:0] rn,
                       input logic [3:0] rm, output int acc);
    req_valid = 1'b1;
    req_fop   = f;
    req_bank  = b;
    req_rn    = rn;
    req_rm    = rm;
    acc       = -1;
    for (int k = 0; k < 60; k++) begin
      run_cycle();
      if (obs_ready === 1'b1) begin
        acc = now - 1 - t0;
        break;
      end
    end
    req_valid = 1'b0;
  endtask

  initial begin
    int a;
    rst       = 1'b0;
    req_valid = 1'b0;
    req_fop   = 4'h0;
    req_bank  = 1'b0;
    req_rn    = 4'h0;
    req_rm    = 4'h0;
    repeat (2) @(posedge clk);
    #1;

    check("rst_busy", busy, 32'h0);
    check("rst_wbv", wb_exp_valid, 1'b0);
    check("rst_wbtag", wb_exp_tag, 5'h0);
    req_valid = 1'b1;
    req_fop   = 4'hF;
    #1;
    check("rst_ready", req_ready, 1'b0);
    check("rst_iss", {iss_fma, iss_div, iss_cmp, iss_bad}, 4'b0000);
    req_valid = 1'b0;

    // Independent back-to-back FADDs.
    scen_reset();
    offer(FADD, 1'b0, 4'd1, 4'd8, a);  check("s1_acc1", a, 0);
    offer(FADD, 1'b0, 4'd2, 4'd9, a);  check("s1_acc2", a, 1);
    offer(FADD, 1'b0, 4'd3, 4'd10, a); check("s1_acc3", a, 2);
    idle(6);
    check("s1_wb3", wb_log[3], -1);
    check("s1_wb4", wb_log[4], 1);
    check("s1_wb5", wb_log[5], 2);
    check("s1_wb6", wb_log[6], 3);

    // RAW on FR1.
    scen_reset();
    offer(FADD, 1'b0, 4'd1, 4'd8, a); check("s2_acc1", a, 0);
    offer(FADD, 1'b0, 4'd2, 4'd1, a); check("s2_acc2", a, 5);
    check("s2_busy0", busy_log[0][1], 1'b0);
    check("s2_busy1", busy_log[1][1], 1'b1);
    check("s2_busy4", busy_log[4][1], 1'b1);
    check("s2_busy5", busy_log[5][1], 1'b0);

    // FMUL colliding with an FDIV write slot.
    scen_reset();
    offer(FDIV, 1'b0, 4'd4, 4'd8, a); check("s3_acc_div", a, 0);
    idle(7);
    offer(FMUL, 1'b0, 4'd5, 4'd9, a); check("s3_acc_mul", a, 9);
    idle(6);
    check("s3_wb12", wb_log[12], 4);
    check("s3_wb13", wb_log[13], 5);

    // Divider occupancy.
    scen_reset();
    offer(FSQRT, 1'b0, 4'd6, 4'd0, a); check("s4_acc_sqrt", a, 0);
    offer(FDIV, 1'b0, 4'd7, 4'd8, a);  check("s4_acc_div", a, 12);
    idle(14);
    check("s4_wb12", wb_log[12], 6);
    check("s4_wb24", wb_log[24], 7);

    // FMAC implicit FR0 source, same bank then other bank.
    scen_reset();
    offer(FADD, 1'b1, 4'd0, 4'd8, a); check("s5_acc_add", a, 0);
    offer(FMAC, 1'b1, 4'd3, 4'd2, a); check("s5_acc_mac", a, 5);
    check("s5_tag", tag_log[5], 5'h13);
    scen_reset();
    offer(FADD, 1'b0, 4'd0, 4'd8, a); check("s5b_acc_add", a, 0);
    offer(FMAC, 1'b1, 4'd3, 4'd2, a); check("s5b_acc_mac", a, 1);

    // Reset with an FDIV in flight.
    scen_reset();
    offer(FDIV, 1'b0, 4'd4, 4'd8, a); check("s6_acc_div", a, 0);
    idle(2);
    rst = 1'b0;
    run_cycle();
    rst = 1'b1;
    offer(FDIV, 1'b0, 4'd4, 4'd8, a); check("s6_acc_div2", a, 4);
    check("s6_busy4", busy_log[4], 32'h0);
    check("s6_wb4", wb_log[4], -1);
    idle(13);
    check("s6_wb12", wb_log[12], -1);
    check("s6_wb16", wb_log[16], 4);

    // Random traffic over a small register window to provoke hazards.
    scen_reset();
    for (int n = 0; n < 4000; n++) begin
      if (!(req_valid && obs_ready !== 1'b1)) begin
        req_valid = ($urandom_range(0, 3) != 0);
        req_fop   = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 7)) : 4'($urandom_range(8, 15));
        req_bank  = 1'($urandom_range(0, 1));
        req_rn    = 4'($urandom_range(0, 7));
        req_rm    = 4'($urandom_range(0, 7));
      end
      rst = ($urandom_range(0, 299) != 0);
      run_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sh4_fpu_issue.md
# sh4_fpu_issue

Issue controller and scoreboard in front of `sh4_fpu`. It accepts decoded FP operations from the decode stage and tracks pending writes to all 32 FP registers (two banks of 16). It dispatches each operation to the FMA, divide/sqrt or compare path once all hazards are resolved, which also shares the single FPU register write port between the FMA and divide paths without collisions.

## Interface
Parameters:
- `FMA_LAT`, default 4: cycles from FMA issue to its register write (`out_valid`).
- `DIV_LAT`, default 12: cycles from FDIV/FSQRT issue to its register write. Must be greater than `FMA_LAT`.

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-low reset.
- `req_valid` in 1: decode presents an operation.
- `req_ready` out 1: operation accepted this cycle. Combinational.
- `req_fop` in 4: `FOP_*` code.
- `req_bank` in 1: FPSCR.FR at decode.
- `req_rn` in 4: destination register; also source h.
- `req_rm` in 4: source l.
- `iss_fma` out 1: one-cycle pulse, drive `sh4_fpu` with an FMA-class op.
- `iss_div` out 1: one-cycle pulse, drive `sh4_fpu` with FDIV/FSQRT.
- `iss_cmp` out 1: one-cycle pulse, drive `sh4_fpu` with FCMP/EQ or FCMP/GT.
- `iss_bad` out 1: one-cycle pulse, unsupported fop was consumed and dropped.
- `iss_tag` out 5: {bank, rn} of the issued operation.
- `wb_exp_valid` out 1: a register write is scheduled in this cycle.
- `wb_exp_tag` out 5: tag of that scheduled write.
- `busy` out 32: pending-write bitmap, indexed by {bank, reg}, for the LSU's FMOV stall.

## Operation
- Classes:
  - FADD, FSUB, FMUL, FMAC are FMA class.
  - FDIV, FSQRT are DIV class.
  - FCMP/EQ, FCMP/GT are CMP class: T only, no register write.
  - All other fops are BAD.
- Sources by op:
  - FADD, FSUB, FMUL, FDIV, CMP read {bank,rn} and {bank,rm}.
  - FMAC additionally reads {bank,0}.
  - FSQRT reads {bank,rn} only.
- Destination: {bank,rn} for FMA and DIV classes.
- `req_ready` = `req_valid` & all of:
  - No source busy (RAW).
  - Destination not busy (WAW).
  - FMA class: `rsv[FMA_LAT]`==0.
  - DIV class: `div_cnt`==0 and `rsv[DIV_LAT]`==0.
  - BAD class: always ready.
- Write-port reservation:
  - `rsv` is a (DIV_LAT+1)-entry shift register of {valid, tag}.
  - It shifts toward index 0 every cycle.
  - An issue loads entry L (FMA_LAT or DIV_LAT) with {1, tag}.
  - Entry 0 drives `wb_exp_valid`/`wb_exp_tag`.
- Scoreboard:
  - Issue at cycle t sets `busy[tag]` at the t edge.
  - Entry 0 valid clears `busy[wb_exp_tag]` at the edge of the writeback cycle.
  - The set-on-issue and clear-on-writeback cannot hit the same tag in the same cycle, because WAW is blocked.
- Divide occupancy: `div_cnt` loads DIV_LAT-1 on DIV issue and decrements to 0.
- Exactly one `iss_*` pulses per accepted request; `iss_*` and `iss_tag` are combinational with `req_ready`.
- No double-precision support (FPSCR.PR=0 only).

## Timing
- Reset values: `busy`=0, `rsv` all invalid, `div_cnt`=0, `wb_exp_valid`=0, `wb_exp_tag`=0. `req_ready`=0 and all `iss_*`=0 while `rst`=0.
- FMA issued at cycle t: `wb_exp_valid` at t+FMA_LAT; `busy` high for t+1..t+FMA_LAT; a dependent op may issue at t+FMA_LAT+1.
- DIV issued at cycle t: write at t+DIV_LAT; the next DIV may issue at t+DIV_LAT.
- CMP and BAD: zero latency, no state change.
- Collision rule: an FMA whose slot t+FMA_LAT is already reserved by an earlier DIV stalls one cycle per conflict.
- Reset mid-operation clears all state in one cycle. `sh4_fpu` shares `rst`, so in-flight results are discarded.
- `req_*` must hold stable while `req_valid` & !`req_ready`.

## Test plan
- Independent back-to-back FADD FR1, FR2, FR3 (bank 0) at cycles 0, 1, 2 → all accepted; `wb_exp_tag` = 1, 2, 3 at cycles 4, 5, 6.
- FADD FR1 at cycle 0, then FADD FR2,FR1 → stalled, accepted at cycle 5; `busy[1]` high for cycles 1–4.
- FDIV FR4 at cycle 0, FMUL FR5 offered at cycle 8 → stalled at 8, issued at 9; `wb_exp_tag` = 4 at 12, 5 at 13.
- FSQRT FR6 at 0, FDIV FR7 offered at 1 → accepted at cycle 12; write at 24.
- FMAC FR3 (bank 1) with FR0 bank 1 busy from a FADD at cycle 0 → issued at 5, `iss_tag`=5'h13. FMAC with FR0 bank 0 busy instead → no stall.
- FDIV FR4 at 0, `rst`=0 at cycle 3 → `busy`=0 and `wb_exp_valid`=0 from cycle 4; a new FDIV is accepted at the first cycle after `rst` returns to 1.
